// File: rtl/mem_to_uart.sv
// Reads NUM_WORDS bytes from a matrix memory and sends each as a UART frame on tx_data.
// Define MEM_TO_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module mem_to_uart #(
    parameter int CLK_DIV   = 5208,
    parameter int NUM_WORDS = 4,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        data,
    output logic              read,
    output logic [ADDR_W-1:0] read_address,
    output logic              tx_data,
    output logic              busy,
    output logic              done
);

`ifdef MEM_TO_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BAUD_W = $clog2(CLK_DIV);

    // Handshake: read is a one-cycle request; the memory presents data on the following cycle.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [3:0]          bit_q, bit_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
`ifdef MEM_TO_UART_PARITY_EN
    logic                parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
`ifdef MEM_TO_UART_PARITY_EN
        parity_d = parity_q;
`endif
        read    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                read    = 1'b1;
                busy    = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                busy    = 1'b1;
                shift_d = data;
                bit_d   = '0;
                baud_d  = '0;
`ifdef MEM_TO_UART_PARITY_EN
                parity_d = ^data;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                busy = 1'b1;
                // tx is registered, so the line lags the bit counter by one cycle.
                if (bit_q == 4'd0)
                    tx_d = 1'b0;
                else if (bit_q <= 4'd8)
                    tx_d = shift_q[0];
`ifdef MEM_TO_UART_PARITY_EN
                else if (bit_q == 4'd9)
                    tx_d = parity_q;
`endif
                else
                    tx_d = 1'b1;
                if (baud_q == BAUD_W'(CLK_DIV - 1)) begin
                    baud_d = '0;
                    if (bit_q >= 4'd1 && bit_q <= 4'd8)
                        shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 4'(FRAME_BITS - 1))
                        state_d = S_NEXT;
                    else
                        bit_d = bit_q + 4'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (index_q == ADDR_W'(NUM_WORDS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef MEM_TO_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef MEM_TO_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign read_address = index_q;
    assign tx_data      = tx_q;

endmodule
